// File: rtl/mem1_stage_pkg.sv
// mem1_stage_pkg: shared definitions for the second memory stage.
//   - datapath / register-index widths
//   - load-type encodings carried in the MEM pipeline register
//   - miss-handling FSM state encodings
package mem1_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // Load-type encodings. 3'd7 is not assigned and is decoded as LW.
  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;
  localparam logic [2:0] LT_LWL = 3'd5;
  localparam logic [2:0] LT_LWR = 3'd6;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } mem1_state_e;

endpackage

// File: rtl/mem1_stage_if.sv
// mem1_stage_if: MEM-register contents in, WB-register contents out.
// Handshake: the MEM register loads a new instruction in any cycle where
// mem_allowin is high; the WB register loads in any cycle where wb_allowin
// is high, and wb_valid marks whether what it loaded is a live instruction.
// Modports:
//   slave  - the stage (consumes in_*/dcache_*/wb_allowin, drives wb_*/mem_allowin)
//   master - the surrounding pipeline / testbench
interface mem1_stage_if;
  import mem1_stage_pkg::*;

  logic              flush;
  logic              in_valid;
  logic [31:0]       in_pc;
  logic              in_is_load;
  logic [2:0]        in_load_type;
  logic              in_unhit;
  logic              in_exception;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_rf_data;
  logic [REG_AW-1:0] in_write_reg;
  logic              in_reg_write;
  logic [DATA_W-1:0] dcache_rdata;
  logic              dcache_data_ok;
  logic              wb_allowin;
  logic              mem_allowin;
  logic              wb_valid;
  logic [31:0]       wb_pc;
  logic [REG_AW-1:0] wb_write_reg;
  logic              wb_reg_write;
  logic [DATA_W-1:0] wb_wdata;

  modport slave (
    input  flush, in_valid, in_pc, in_is_load, in_load_type, in_unhit,
           in_exception, in_alu_result, in_rf_data, in_write_reg,
           in_reg_write, dcache_rdata, dcache_data_ok, wb_allowin,
    output mem_allowin, wb_valid, wb_pc, wb_write_reg, wb_reg_write, wb_wdata
  );

  modport master (
    output flush, in_valid, in_pc, in_is_load, in_load_type, in_unhit,
           in_exception, in_alu_result, in_rf_data, in_write_reg,
           in_reg_write, dcache_rdata, dcache_data_ok, wb_allowin,
    input  mem_allowin, wb_valid, wb_pc, wb_write_reg, wb_reg_write, wb_wdata
  );

endinterface

// File: rtl/mem1_stage_load_align.sv
// mem1_load_align: combinational load-data extraction (little-endian).
// Ports: word (raw cache word), addr (byte offset), load_type, rt (old
// destination value for LWL/LWR merge) -> wdata.
// Macro MEM1_UNALIGNED_EN: when defined, LWL/LWR merge with rt; otherwise
// they behave as LW and rt is ignored.
module mem1_load_align
  import mem1_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  load_type,
  input  logic [31:0] rt,
  output logic [31:0] wdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*addr +: 8];
    half_sel = addr[1] ? word[31:16] : word[15:0];
  end

`ifdef MEM1_UNALIGNED_EN
  always_comb begin
    case (load_type)
      LT_LB:   wdata = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  wdata = {24'd0, byte_sel};
      LT_LH:   wdata = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  wdata = {16'd0, half_sel};
      LT_LWL: begin
        case (addr)
          2'd0:    wdata = {word[7:0],  rt[23:0]};
          2'd1:    wdata = {word[15:0], rt[15:0]};
          2'd2:    wdata = {word[23:0], rt[7:0]};
          default: wdata = word;
        endcase
      end
      LT_LWR: begin
        case (addr)
          2'd0:    wdata = word;
          2'd1:    wdata = {rt[31:24], word[31:8]};
          2'd2:    wdata = {rt[31:16], word[31:16]};
          default: wdata = {rt[31:8],  word[31:24]};
        endcase
      end
      default: wdata = word;
    endcase
  end
`else
  logic unused_rt;
  assign unused_rt = ^rt;

  always_comb begin
    case (load_type)
      LT_LB:   wdata = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  wdata = {24'd0, byte_sel};
      LT_LH:   wdata = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  wdata = {16'd0, half_sel};
      default: wdata = word;
    endcase
  end
`endif

endmodule

// File: rtl/mem1_stage.sv
// mem1_stage: second memory stage. Completes loads (waits on dcache misses,
// aligns/extends data) and holds the WB pipeline register.
// Ports: clk, reset (sync, active-high), bus (mem1_stage_if.slave: MEM
// register contents, dcache return, WB register, mem_allowin), dbg_state
// (current miss-handling FSM state).
// Macro MEM1_UNALIGNED_EN enables LWL/LWR merging in mem1_load_align.
module mem1_stage
  import mem1_stage_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int REG_AW_P = REG_AW
) (
  input  logic        clk,
  input  logic        reset,
  mem1_stage_if.slave bus,
  output mem1_state_e dbg_state
);

  mem1_state_e         state, state_next;
  logic                need_wait;
  logic                result_ready;
  logic                hold_load;
  logic [DATA_W_P-1:0] hold_buf;
  logic [DATA_W_P-1:0] raw_word;
  logic [DATA_W_P-1:0] load_data;
  logic [DATA_W_P-1:0] result;
  logic [REG_AW_P-1:0] write_reg;

  assign need_wait = bus.in_valid & bus.in_is_load & bus.in_unhit & ~bus.in_exception;
  assign write_reg = bus.in_write_reg;
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Next-state logic. Flush wins over everything; a flush during WAIT must
  // still swallow the refill already in flight (DRAIN), unless that refill
  // arrives in the same cycle.
  always_comb begin
    state_next = state;
    if (bus.flush) begin
      if ((state == ST_WAIT || state == ST_DRAIN) && !bus.dcache_data_ok)
        state_next = ST_DRAIN;
      else
        state_next = ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (need_wait) state_next = ST_WAIT;
        ST_WAIT:  if (bus.dcache_data_ok) state_next = bus.wb_allowin ? ST_RUN : ST_HOLD;
        ST_HOLD:  if (bus.wb_allowin) state_next = ST_RUN;
        ST_DRAIN: if (bus.dcache_data_ok) state_next = ST_RUN;
        default:  state_next = ST_RUN;
      endcase
    end
  end

  // Output logic
  always_comb begin
    result_ready = 1'b0;
    hold_load    = 1'b0;
    case (state)
      ST_RUN:   result_ready = bus.in_valid & ~need_wait;
      ST_WAIT: begin
        result_ready = bus.dcache_data_ok;
        hold_load    = bus.dcache_data_ok & ~bus.wb_allowin;
      end
      ST_HOLD:  result_ready = 1'b1;
      default:  result_ready = 1'b0;
    endcase
    bus.mem_allowin = (state != ST_DRAIN) & (~bus.in_valid | (result_ready & bus.wb_allowin));
  end

  // Refill word parked while WB is stalled.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) hold_buf <= '0;
    else if (hold_load)     hold_buf <= bus.dcache_rdata;
  end

  assign raw_word = (state == ST_HOLD) ? hold_buf : bus.dcache_rdata;

  mem1_load_align u_align (
    .word      (raw_word),
    .addr      (bus.in_alu_result[1:0]),
    .load_type (bus.in_load_type),
    .rt        (bus.in_rf_data),
    .wdata     (load_data)
  );

  assign result = bus.in_is_load ? load_data : bus.in_alu_result;

  // WB pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.wb_valid     <= 1'b0;
      bus.wb_pc        <= '0;
      bus.wb_write_reg <= '0;
      bus.wb_reg_write <= 1'b0;
      bus.wb_wdata     <= '0;
    end else if (bus.flush) begin
      bus.wb_valid     <= 1'b0;
    end else if (bus.wb_allowin) begin
      bus.wb_valid     <= bus.in_valid & result_ready;
      bus.wb_pc        <= bus.in_pc;
      bus.wb_write_reg <= write_reg;
      bus.wb_reg_write <= bus.in_reg_write & ~bus.in_exception;
      bus.wb_wdata     <= result;
    end
  end

endmodule

// File: tb/tb_mem1_stage.sv
// tb_mem1_stage: directed self-checking bench for mem1_stage.
module tb_mem1_stage;
  import mem1_stage_pkg::*;

  logic        clk;
  logic        reset;
  mem1_state_e dbg_state;
  int          n_checks = 0;
  int          n_fail   = 0;

  mem1_stage_if bus ();

  mem1_stage dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.flush          = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_pc          = 32'h0;
    bus.in_is_load     = 1'b0;
    bus.in_load_type   = LT_LW;
    bus.in_unhit       = 1'b0;
    bus.in_exception   = 1'b0;
    bus.in_alu_result  = 32'h0;
    bus.in_rf_data     = 32'h0;
    bus.in_write_reg   = 5'd0;
    bus.in_reg_write   = 1'b0;
    bus.dcache_rdata   = 32'h0;
    bus.dcache_data_ok = 1'b0;
    bus.wb_allowin     = 1'b1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic is_load, input logic [2:0] lt,
                       input logic [31:0] addr, input logic unhit, input logic [31:0] rdata);
    bus.in_valid      = 1'b1;
    bus.in_pc         = pc;
    bus.in_is_load    = is_load;
    bus.in_load_type  = lt;
    bus.in_alu_result = addr;
    bus.in_unhit      = unhit;
    bus.dcache_rdata  = rdata;
    bus.in_write_reg  = pc[6:2];
    bus.in_reg_write  = 1'b1;
  endtask

  // Checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    settle();

    // Reset state
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_wdata", bus.wb_wdata, 32'h0);
    check("rst_wb_pc", bus.wb_pc, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_RUN));
    check("rst_allowin", 32'(bus.mem_allowin), 32'd1);

    // 1: hit LB, addr 2
    issue(32'h100, 1'b1, LT_LB, 32'h1000_0002, 1'b0, 32'h1280_3456);
    settle();
    check("t1_allowin", 32'(bus.mem_allowin), 32'd1);
    step();
    idle();
    check("t1_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("t1_wdata", bus.wb_wdata, 32'hFFFF_FF80);
    check("t1_pc", bus.wb_pc, 32'h100);
    check("t1_wreg", 32'(bus.wb_write_reg), 32'd0);
    check("t1_regwr", 32'(bus.wb_reg_write), 32'd1);

    // Hit LH addr 2, LBU addr 3, non-load passthrough
    issue(32'h104, 1'b1, LT_LH, 32'h2002, 1'b0, 32'h8001_1234);
    step();
    check("lh_wdata", bus.wb_wdata, 32'hFFFF_8001);
    check("lh_wreg", 32'(bus.wb_write_reg), 32'd1);
    issue(32'h108, 1'b1, LT_LBU, 32'h2003, 1'b0, 32'hF011_2233);
    step();
    check("lbu_wdata", bus.wb_wdata, 32'h0000_00F0);
    issue(32'h10C, 1'b0, LT_LW, 32'hCAFE_F00D, 1'b0, 32'h0);
    step();
    idle();
    check("alu_wdata", bus.wb_wdata, 32'hCAFE_F00D);
    check("alu_valid", 32'(bus.wb_valid), 32'd1);

    // 2: miss LW, data_ok after 5 stalled cycles
    issue(32'h200, 1'b1, LT_LW, 32'h3000, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("t2_stall%0d", i), 32'(bus.mem_allowin), 32'd0);
      step();
    end
    check("t2_state_wait", 32'(dbg_state), 32'(ST_WAIT));
    check("t2_wb_bubble", 32'(bus.wb_valid), 32'd0);
    bus.dcache_data_ok = 1'b1;
    bus.dcache_rdata   = 32'hDEAD_BEEF;
    settle();
    check("t2_allowin_ok", 32'(bus.mem_allowin), 32'd1);
    step();
    idle();
    check("t2_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("t2_wdata", bus.wb_wdata, 32'hDEAD_BEEF);
    check("t2_state_run", 32'(dbg_state), 32'(ST_RUN));

    // 3: miss LHU, WB stalled when data arrives -> HOLD
    issue(32'h300, 1'b1, LT_LHU, 32'h4000, 1'b1, 32'h0);
    step();
    bus.dcache_data_ok = 1'b1;
    bus.dcache_rdata   = 32'hA5A5_8001;
    bus.wb_allowin     = 1'b0;
    settle();
    check("t3_allowin_stall", 32'(bus.mem_allowin), 32'd0);
    step();
    bus.dcache_data_ok = 1'b0;
    bus.dcache_rdata   = 32'h0;
    check("t3_state_hold", 32'(dbg_state), 32'(ST_HOLD));
    bus.dcache_data_ok = 1'b1;   // stray data_ok in HOLD must be ignored
    bus.dcache_rdata   = 32'h7777_7777;
    step();
    bus.dcache_data_ok = 1'b0;
    check("t3_still_hold", 32'(dbg_state), 32'(ST_HOLD));
    bus.wb_allowin = 1'b1;
    settle();
    check("t3_allowin_rel", 32'(bus.mem_allowin), 32'd1);
    step();
    idle();
    check("t3_wdata", bus.wb_wdata, 32'h0000_8001);
    check("t3_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("t3_state_run", 32'(dbg_state), 32'(ST_RUN));

    // 4: flush in WAIT, refill 3 cycles later is drained
    issue(32'h400, 1'b1, LT_LW, 32'h5000, 1'b1, 32'h0);
    step();
    bus.flush = 1'b1;
    step();
    idle();
    check("t4_state_drain", 32'(dbg_state), 32'(ST_DRAIN));
    check("t4_wb_killed", 32'(bus.wb_valid), 32'd0);
    check("t4_allowin_drain", 32'(bus.mem_allowin), 32'd0);
    step();
    step();
    bus.dcache_data_ok = 1'b1;
    bus.dcache_rdata   = 32'h0BAD_0BAD;
    settle();
    check("t4_allowin_okcyc", 32'(bus.mem_allowin), 32'd0);
    step();
    idle();
    check("t4_state_run", 32'(dbg_state), 32'(ST_RUN));
    check("t4_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("t4_allowin_after", 32'(bus.mem_allowin), 32'd1);

    // Flush together with data_ok in WAIT -> RUN, not DRAIN
    issue(32'h480, 1'b1, LT_LW, 32'h5004, 1'b1, 32'h0);
    step();
    bus.flush          = 1'b1;
    bus.dcache_data_ok = 1'b1;
    bus.dcache_rdata   = 32'h1234_5678;
    step();
    idle();
    check("fok_state", 32'(dbg_state), 32'(ST_RUN));
    check("fok_wb_valid", 32'(bus.wb_valid), 32'd0);

    // Stray data_ok in RUN is ignored
    bus.dcache_data_ok = 1'b1;
    step();
    idle();
    check("run_ok_ignored", 32'(dbg_state), 32'(ST_RUN));

    // 5: exception load with unhit -> no wait, no register write
    issue(32'h500, 1'b1, LT_LW, 32'h6000, 1'b1, 32'h55);
    bus.in_exception = 1'b1;
    settle();
    check("t5_allowin", 32'(bus.mem_allowin), 32'd1);
    step();
    idle();
    check("t5_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("t5_regwr", 32'(bus.wb_reg_write), 32'd0);
    check("t5_state", 32'(dbg_state), 32'(ST_RUN));

    // 6: LWL addr 1
    issue(32'h600, 1'b1, LT_LWL, 32'h7001, 1'b0, 32'h1122_3344);
    bus.in_rf_data = 32'hAABB_CCDD;
    step();
    idle();
`ifdef MEM1_UNALIGNED_EN
    check("t6_lwl", bus.wb_wdata, 32'h3344_CCDD);
`else
    check("t6_lwl", bus.wb_wdata, 32'h1122_3344);
`endif

    // LWR addr 2
    issue(32'h604, 1'b1, LT_LWR, 32'h7002, 1'b0, 32'h1122_3344);
    bus.in_rf_data = 32'hAABB_CCDD;
    step();
    idle();
`ifdef MEM1_UNALIGNED_EN
    check("lwr_a2", bus.wb_wdata, 32'hAABB_1122);
`else
    check("lwr_a2", bus.wb_wdata, 32'h1122_3344);
`endif

    // Flush on a hit instruction kills the WB entry
    issue(32'h700, 1'b1, LT_LW, 32'h8000, 1'b0, 32'h9999_9999);
    bus.flush = 1'b1;
    step();
    idle();
    check("flush_hit_valid", 32'(bus.wb_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem1_stage.md
Name: mem1_stage

Overview:
Second memory stage. It consumes the MEM pipeline-register contents and completes loads: it waits on data-cache misses, then extracts and sign- or zero-extends the load data. It also holds the write-back pipeline register (WB_*) and drives mem_allowin, which becomes the upstream register's write enable. An instruction whose cache access hit, or that is not a load, passes to WB in one cycle.

Parameters:
DATA_W, 32, datapath width; only 32 is supported.
REG_AW, 5, architectural register index width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
flush  in  1  pipeline flush (exception/eret); kills the MEM and WB contents
in_valid  in  1  MEM register holds a live instruction
in_pc  in  32  instruction PC
in_is_load  in  1  instruction is a load
in_load_type  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 treated as LW
in_unhit  in  1  data access missed; data arrives later via dcache_data_ok
in_exception  in  1  exception already recorded for this instruction
in_alu_result  in  32  ALU result / load address
in_rf_data  in  32  old rt value, used for LWL/LWR merge
in_write_reg  in  5  destination register
in_reg_write  in  1  writes the register file
dcache_rdata  in  32  cache read data; valid on a hit, or in the cycle dcache_data_ok is high
dcache_data_ok  in  1  refill data valid pulse
wb_allowin  in  1  WB consumer accepts this cycle
mem_allowin  out  1  MEM register may load a new instruction
wb_valid  out  1  WB register valid
wb_pc  out  32  WB PC
wb_write_reg  out  5  WB destination register
wb_reg_write  out  1  WB register-file write enable
wb_wdata  out  32  WB write data

Behaviour:
- Reset: state=RUN, wb_valid=0, wb_pc=0, wb_write_reg=0, wb_reg_write=0, wb_wdata=0, hold buffer=0.
- need_wait = in_valid & in_is_load & in_unhit & ~in_exception.
- States:
  - RUN: result_ready = in_valid & ~need_wait. If need_wait, go to WAIT.
  - WAIT: when dcache_data_ok=1, result_ready=1. If wb_allowin=0 in that cycle, latch dcache_rdata into the hold buffer and go to HOLD; otherwise go to RUN.
  - HOLD: result_ready=1 and load data is taken from the hold buffer. Return to RUN on wb_allowin.
  - DRAIN: entered when flush arrives while in WAIT. The next dcache_data_ok is discarded, then go to RUN. During DRAIN mem_allowin=0.
- mem_allowin = (state!=DRAIN) & (~in_valid | (result_ready & wb_allowin)).
- WB register: loads when wb_allowin=1.
  - wb_valid <= in_valid & result_ready & ~flush.
  - Other WB fields are loaded from the current instruction.
  - wb_reg_write <= in_reg_write & ~in_exception.
- Latency: hit loads and non-loads reach WB 1 cycle after in_valid. A miss reaches WB 1 cycle after the accepted dcache_data_ok (or after HOLD releases).
- Load data extraction (little-endian; addr = in_alu_result[1:0]):
  - LW: the full word.
  - LB/LBU: byte addr, sign- or zero-extended.
  - LH/LHU: halfword addr[1], sign- or zero-extended. The address is already checked aligned upstream.
  - Non-load instructions pass in_alu_result.
- flush: state goes to RUN (or DRAIN from WAIT), hold buffer is cleared, and wb_valid<=0. Flush has priority over every other event in the same cycle.
- A dcache_data_ok arriving in RUN or HOLD is ignored and does not change state.
- A flush and a dcache_data_ok in the same WAIT cycle: the data is discarded and the state goes to RUN, not DRAIN.

Optional Feature:
MEM1_UNALIGNED_EN
- Defined: load types 5 and 6 merge the loaded word with in_rf_data.
  - LWL by addr 0..3: {w[7:0],rt[23:0]}, {w[15:0],rt[15:0]}, {w[23:0],rt[7:0]}, w.
  - LWR by addr 0..3: w, {rt[31:24],w[31:8]}, {rt[31:16],w[31:16]}, {rt[31:8],w[31:24]}.
- Undefined: types 5 and 6 behave as LW, and in_rf_data is unused.

Decomposition:
- Shared package/header (alongside the pipeline register defines):
  - load-type encodings LT_LW..LT_LWR;
  - state encodings ST_RUN, ST_WAIT, ST_HOLD, ST_DRAIN.
- One combinational sub-module, mem1_load_align. Inputs: raw word, addr[1:0], load type, rt. Output: write data.

Test Plan:
1. Hit LB, addr=2, dcache_rdata=0x12_80_34_56, wb_allowin=1 -> next cycle wb_valid=1, wb_wdata=0xFFFFFF80; mem_allowin stays 1.
2. Miss LW, data_ok asserted 5 cycles later with 0xDEADBEEF -> mem_allowin=0 for those 5 cycles; wb_wdata=0xDEADBEEF one cycle after data_ok.
3. Miss LHU, wb_allowin=0 during data_ok, rdata=0xA5A5_8001, addr=0 -> state HOLD; when wb_allowin rises, wb_wdata=0x00008001 and the state returns to RUN.
4. Flush in WAIT, data_ok 3 cycles later -> that data_ok is dropped, wb_valid stays 0, and mem_allowin=1 the cycle after it.
5. Load with in_exception=1 and in_unhit=1 -> no wait; wb_valid=1 and wb_reg_write=0 next cycle.
6. With MEM1_UNALIGNED_EN: LWL addr=1, w=0x11223344, rt=0xAABBCCDD -> wb_wdata=0x3344CCDD. Without the macro -> 0x11223344.
